mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter and sequencer in front of the single-port 32×8 program/data memory of the CISC core. It shares the memory between the instruction-fetch requester (port 0) and the operand/data requester (port 1). Each accepted request is issued to the memory one cycle later, and read data is returned with a tagged valid one cycle after that. The pipeline sustains one access per cycle.

## Interface
Parameters:
- PRIO_MODE, 0: arbitration mode. 0 = round-robin; 1 = port 1 has fixed priority.
- MAX_WAIT, 4: PRIO_MODE=1 only. This is the number of consecutive cycles port 0 may be denied before it is force-granted. Range 1–15.

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- req0 / req1  in  1  request level; held, with its qualifiers, until granted
- we0 / we1  in  1  1 = write, 0 = read
- addr0 / addr1  in  5  word address
- wdata0 / wdata1  in  8  write data
- gnt0 / gnt1  out  1  one-cycle pulse: request accepted this cycle
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata valid for that port's read
- rdata  out  8  read data, shared; qualified by rvalid0/rvalid1
- mem_read  out  1  memory READ strobe (registered)
- mem_write  out  1  memory WRITE strobe (registered)
- mem_addr  out  5  memory address (registered)
- mem_wdata  out  8  memory write data (registered)
- mem_rdata  in  8  memory read data; valid the cycle after mem_read

## Operation
- **Stage A (arbitrate, combinational grant):**
  - At most one of gnt0/gnt1 is high per cycle.
  - gnt is asserted only when its req is high.
  - There is no back-pressure: a request can be granted every cycle.
- **PRIO_MODE=0:**
  - The single pending requester wins.
  - If both are pending, the port not granted last wins.
  - The last-grant pointer resets to port 1, so port 0 wins the first tie.
- **PRIO_MODE=1:**
  - Port 1 wins ties.
  - A 4-bit starvation counter increments each cycle in which req0=1 and gnt0=0.
  - When the counter equals MAX_WAIT, port 0 wins the next tie.
  - The counter clears on gnt0 or when req0=0.
- **Stage B (issue register):**
  - On a grant, mem_read=~we, mem_write=we, and mem_addr/mem_wdata are loaded from the winner.
  - An issue-source tag and an issue-is-read flag are also captured.
  - With no grant, mem_read=mem_write=0; mem_addr and mem_wdata hold their values.
- **Stage C (response):**
  - If stage B held a read, the response tag selects the port: rvalid0 or rvalid1 pulses.
  - rdata = mem_rdata (combinational pass-through).
  - Writes produce no rvalid.
- **Ordering:** accesses reach memory strictly in grant order. A read granted the cycle after a write to the same address returns the new data.
- **Reset:**
  - All registers clear: mem_read, mem_write, mem_addr, mem_wdata, gnt*, rvalid*, the starvation counter, and the issue/response valids.
  - Reset asserted mid-operation drops in-flight commands and responses; no rvalid follows reset.
  - rdata follows mem_rdata and is undefined-but-ignored while both rvalids are low.

## Timing
- Cycle N: req sampled, gnt pulses.
- Edge ending N: stage B loaded. During cycle N+1, mem_read or mem_write is high.
- Edge ending N+1: the memory latches the read data or performs the write.
- Cycle N+2: rvalid pulses with rdata. Read latency is 2 cycles from gnt.
- Throughput: 1 access per cycle. Back-to-back reads yield rvalid on consecutive cycles.
- A requester may drop req in the cycle after gnt; holding it issues a second access.
- Simultaneous req0 and req1 every cycle, PRIO_MODE=0: grants alternate 0,1,0,1…

## Structure
- **Package mem_pkg:** MEM_ADDR_W=5, MEM_DATA_W=8, PORT_IFETCH=0, PORT_DATA=1, and the stage B/C tag record (valid, src, is_read).
- **Sub-module mem_arb_pick:** combinational two-way pick plus the last-grant/starvation state. It takes PRIO_MODE and MAX_WAIT.
- The top level holds the stage B/C registers and the output muxing.

## Test plan
- After reset, req0 read addr 5'h00 → gnt0 in cycle N, mem_read=1 in N+1, rvalid0 and rdata=8'hBF in N+2; rvalid1 stays 0.
- Port 1 writes 8'h3C to 5'h1A, then reads 5'h1A on the next cycle → write issued in N+1, read issued in N+2, rvalid1 with rdata=8'h3C in N+3.
- PRIO_MODE=0, both ports read continuously (port 0: 5'h00; port 1: 5'h1C) → grants 0,1,0,1; rdata alternates 8'hBF, 8'h0A.
- PRIO_MODE=1, MAX_WAIT=4, both requesting → port 1 granted for 4 cycles, then gnt0 once, then the pattern repeats.
- Reset asserted the cycle after gnt0 for a read → no rvalid0 ever appears; mem_read=0 the cycle after reset.
- A write-only stream on port 0 → mem_write pulses each cycle with the correct addr/wdata; rvalid0 is never asserted.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared widths, port identifiers and the issue/response tag record for the
// two-port memory arbiter.
package mem_pkg;
    localparam int MEM_ADDR_W = 5;
    localparam int MEM_DATA_W = 8;

    localparam logic PORT_IFETCH = 1'b0;
    localparam logic PORT_DATA   = 1'b1;

    typedef struct packed {
        logic valid;
        logic src;
        logic is_read;
    } mem_tag_t;
endpackage

// File: rtl/mem_arb_pick.sv
// Combinational two-way grant with the round-robin last-grant pointer and the
// port-0 starvation counter used by fixed-priority mode.
import mem_pkg::*;

module mem_arb_pick #(
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    output logic gnt0,
    output logic gnt1
);
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

    logic       last_gnt;
    logic [3:0] starve_cnt;
    logic       pick1;

    always_comb begin
        pick1 = req1;
        if (req0 && req1) begin
            if (PRIO_MODE == 0) begin
                pick1 = (last_gnt == PORT_IFETCH);
            end else begin
                pick1 = (starve_cnt != MAX_WAIT_C);
            end
        end
        // Nothing is accepted while reset is held, so no command slips past it.
        gnt0 = ~reset & req0 & ~pick1;
        gnt1 = ~reset & req1 & pick1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_gnt   <= PORT_DATA;
            starve_cnt <= '0;
        end else begin
            if (gnt0) begin
                last_gnt <= PORT_IFETCH;
            end else if (gnt1) begin
                last_gnt <= PORT_DATA;
            end
            if (!req0 || gnt0) begin
                starve_cnt <= '0;
            end else begin
                starve_cnt <= starve_cnt + 4'd1;
            end
        end
    end
endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter/sequencer for the shared 32x8 memory: grant, registered
// issue stage, then tagged read response one cycle after issue.
import mem_pkg::*;

module mem_arbiter #(
    parameter int PRIO_MODE = 0,
    parameter int MAX_WAIT  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [MEM_ADDR_W-1:0] addr0,
    input  logic [MEM_ADDR_W-1:0] addr1,
    input  logic [MEM_DATA_W-1:0] wdata0,
    input  logic [MEM_DATA_W-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [MEM_DATA_W-1:0] rdata,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [MEM_DATA_W-1:0] mem_wdata,
    input  logic [MEM_DATA_W-1:0] mem_rdata
);
    logic                  any_gnt;
    logic                  win_we;
    logic [MEM_ADDR_W-1:0] win_addr;
    logic [MEM_DATA_W-1:0] win_wdata;
    mem_tag_t              iss_tag;
    mem_tag_t              rsp_tag;

    mem_arb_pick #(
        .PRIO_MODE (PRIO_MODE),
        .MAX_WAIT  (MAX_WAIT)
    ) u_pick (
        .clk   (clk),
        .reset (reset),
        .req0  (req0),
        .req1  (req1),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    assign any_gnt = gnt0 | gnt1;

    always_comb begin
        win_we    = we0;
        win_addr  = addr0;
        win_wdata = wdata0;
        if (gnt1) begin
            win_we    = we1;
            win_addr  = addr1;
            win_wdata = wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            iss_tag   <= '0;
            rsp_tag   <= '0;
        end else begin
            mem_read  <= any_gnt & ~win_we;
            mem_write <= any_gnt & win_we;
            if (any_gnt) begin
                mem_addr  <= win_addr;
                mem_wdata <= win_wdata;
            end
            iss_tag.valid   <= any_gnt;
            iss_tag.src     <= gnt1;
            iss_tag.is_read <= ~win_we;
            rsp_tag         <= iss_tag;
        end
    end

    // Memory returns read data the cycle after the strobe, so the response
    // tag is simply the issue tag delayed by one cycle.
    assign rvalid0 = rsp_tag.valid & rsp_tag.is_read & (rsp_tag.src == PORT_IFETCH);
    assign rvalid1 = rsp_tag.valid & rsp_tag.is_read & (rsp_tag.src == PORT_DATA);
    assign rdata   = mem_rdata;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench: a round-robin instance and a fixed-priority
// instance share the stimulus; issue and response expectations are queued.
module tb_mem_arbiter;
    typedef struct {
        int         due;
        bit         rd;
        bit         wr;
        logic [4:0] addr;
        logic [7:0] wdata;
    } iss_t;

    typedef struct {
        int         due;
        bit         port;
        logic [7:0] data;
    } rsp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, req1, we0, we1;
    logic [4:0] addr0, addr1;
    logic [7:0] wdata0, wdata1;

    logic       a_gnt0, a_gnt1, a_rvalid0, a_rvalid1, a_mem_read, a_mem_write;
    logic [7:0] a_rdata, a_mem_wdata, a_mem_rdata;
    logic [4:0] a_mem_addr;
    logic       b_gnt0, b_gnt1, b_rvalid0, b_rvalid1, b_mem_read, b_mem_write;
    logic [7:0] b_rdata, b_mem_wdata;
    logic [4:0] b_mem_addr;
    wire  [7:0] b_mem_rdata = 8'h00;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    bit [7:0]   mem_a [32];
    bit         wr_a  [32];
    logic [7:0] ref_mem [32];
    iss_t       iss_q [$];
    rsp_t       rsp_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] init_val(input logic [4:0] a);
        case (a)
            5'h00:   return 8'hBF;
            5'h1C:   return 8'h0A;
            default: return {3'b101, a};
        endcase
    endfunction

    always @(posedge clk) begin
        if (a_mem_write) begin
            mem_a[a_mem_addr] <= a_mem_wdata;
            wr_a[a_mem_addr]  <= 1'b1;
        end
        if (a_mem_read) begin
            a_mem_rdata <= wr_a[a_mem_addr] ? mem_a[a_mem_addr] : init_val(a_mem_addr);
        end
    end

    mem_arbiter #(.PRIO_MODE(0), .MAX_WAIT(4)) dut_a (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(a_gnt0), .gnt1(a_gnt1), .rvalid0(a_rvalid0), .rvalid1(a_rvalid1),
        .rdata(a_rdata), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
    );

    mem_arbiter #(.PRIO_MODE(1), .MAX_WAIT(4)) dut_b (
        .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rvalid0), .rvalid1(b_rvalid1),
        .rdata(b_rdata), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    // One clock: check grants, queue expectations, cross the edge, check outputs.
    task automatic tick(input logic [1:0] exp_a, input logic [1:0] exp_b);
        bit         rst_now;
        bit         p;
        bit         w;
        iss_t       ie;
        rsp_t       re;
        #1;
        check("gnt_a", {a_gnt1, a_gnt0}, exp_a);
        check("gnt_b", {b_gnt1, b_gnt0}, exp_b);
        if (exp_a != 2'b00) begin
            p        = exp_a[1];
            w        = p ? we1 : we0;
            ie.due   = cyc + 1;
            ie.rd    = !w;
            ie.wr    = w;
            ie.addr  = p ? addr1 : addr0;
            ie.wdata = p ? wdata1 : wdata0;
            iss_q.push_back(ie);
            if (w) begin
                ref_mem[ie.addr] = ie.wdata;
            end else begin
                re.due  = cyc + 2;
                re.port = p;
                re.data = ref_mem[ie.addr];
                rsp_q.push_back(re);
            end
        end
        rst_now = reset;
        @(posedge clk);
        #1;
        if (rst_now) begin
            iss_q.delete();
            rsp_q.delete();
        end
        if (iss_q.size() > 0 && iss_q[0].due == cyc) begin
            ie = iss_q.pop_front();
            check("mem_read", 16'(a_mem_read), 16'(ie.rd));
            check("mem_write", 16'(a_mem_write), 16'(ie.wr));
            check("mem_addr", 16'(a_mem_addr), 16'(ie.addr));
            if (ie.wr) check("mem_wdata", 16'(a_mem_wdata), 16'(ie.wdata));
        end else begin
            check("mem_strobe_idle", {a_mem_write, a_mem_read}, 16'd0);
        end
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            re = rsp_q.pop_front();
            check("rvalid", {a_rvalid1, a_rvalid0}, re.port ? 16'd2 : 16'd1);
            check("rdata", 16'(a_rdata), 16'(re.data));
        end else begin
            check("rvalid_idle", {a_rvalid1, a_rvalid0}, 16'd0);
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) ref_mem[i] = init_val(5'(i));
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);
        reset = 1'b0;
        check("reset_mem_addr", 16'(a_mem_addr), 16'd0);
        check("reset_mem_wdata", 16'(a_mem_wdata), 16'd0);
        check("reset_rvalid_b", {b_rvalid1, b_rvalid0, b_mem_write, b_mem_read}, 16'd0);

        // single port-0 read of 0x00
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h00;
        tick(2'b01, 2'b01);
        req0 = 1'b0;
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);

        // port-1 write then read-back of the same address
        req1 = 1'b1; we1 = 1'b1; addr1 = 5'h1A; wdata1 = 8'h3C;
        tick(2'b10, 2'b10);
        we1 = 1'b0;
        tick(2'b10, 2'b10);
        req1 = 1'b0;
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);

        // both ports reading every cycle: alternation vs. starvation-bounded priority
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h00;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'h1C;
        for (int i = 0; i < 10; i++) begin
            tick((i % 2 == 0) ? 2'b01 : 2'b10, (i % 5 == 4) ? 2'b01 : 2'b10);
        end
        req0 = 1'b0; req1 = 1'b0;
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);

        // reset right after a read grant drops the response
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h00;
        tick(2'b01, 2'b01);
        reset = 1'b1; req0 = 1'b0;
        tick(2'b00, 2'b00);
        reset = 1'b0;
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);

        // first tie after reset goes to port 0 in round-robin mode
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h00;
        req1 = 1'b1; we1 = 1'b0; addr1 = 5'h1C;
        tick(2'b01, 2'b10);
        tick(2'b10, 2'b10);
        req0 = 1'b0; req1 = 1'b0;
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);

        // write-only stream on port 0, then read one location back
        req0 = 1'b1; we0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            addr0  = 5'(3 + i);
            wdata0 = 8'hA0 + 8'(i);
            tick(2'b01, 2'b01);
        end
        req0 = 1'b0;
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);
        req0 = 1'b1; we0 = 1'b0; addr0 = 5'h04;
        tick(2'b01, 2'b01);
        req0 = 1'b0;
        tick(2'b00, 2'b00);
        tick(2'b00, 2'b00);

        check("iss_queue_drained", 16'(iss_q.size()), 16'd0);
        check("rsp_queue_drained", 16'(rsp_q.size()), 16'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
